// File: rtl/pad_sync_addr_gen.sv
// rtl/pad_sync_addr_gen.sv - pad synchronisation FSM and scratch-pad address generator
//
// Purpose:
//   Watches the ready/full flags of NUM_PADS input scratch pads and produces
//   the mac_begin / interrupt / restore pulses for macc_control. Also generates
//   the weight-pad address, the circular ifmap-pad address and the psum-pad
//   read/write addresses plus write enable for both conv modes.
//
// Build option:
//   PAD_SYNC_HOLDOFF_EN - when defined, a HOLD state with a RESTORE_HOLD-cycle
//   holdoff sits between HALT and RUN. When undefined, HALT returns straight
//   to RUN and RESTORE_HOLD is ignored.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   pad_ready, pad_full       per-pad ready / full flags
//   load_start                one-cycle pulse at the start of a column load
//   mode                      1 = clip/shift conv, 0 = normal 1-D conv
//   conv_len, filter_num      layer geometry for the address maths
//   pixel_num, pixel_point    ifmap ring size and current ring start
//   mul_enable, psum_store,
//   mac_finish                status flags from macc_control
//   cnt_a, cnt_b, cnt_shift   loop counters from macc_control
//   mac_begin, interrupt,
//   restore                   single-cycle control pulses
//   stalled                   high while halted (HALT or HOLD)
//   ifmap_addr, weight_addr   input pad read addresses
//   psum_raddr, psum_waddr,
//   psum_we                   psum pad read/write address and write enable

module pad_sync_addr_gen #(
  parameter int NUM_PADS     = 2,
  parameter int CNT_A_W      = 4,
  parameter int CNT_B_W      = 4,
  parameter int SHIFT_W      = 4,
  parameter int F_ADDR_W     = 5,
  parameter int W_ADDR_W     = 8,
  parameter int P_ADDR_W     = 6,
  parameter int RESTORE_HOLD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PADS-1:0] pad_ready,
  input  logic [NUM_PADS-1:0] pad_full,
  input  logic                load_start,
  input  logic                mode,
  input  logic [CNT_A_W-1:0]  conv_len,
  input  logic [CNT_B_W-1:0]  filter_num,
  input  logic [F_ADDR_W-1:0] pixel_num,
  input  logic [F_ADDR_W-1:0] pixel_point,
  input  logic                mul_enable,
  input  logic                psum_store,
  input  logic                mac_finish,
  input  logic [CNT_A_W-1:0]  cnt_a,
  input  logic [CNT_B_W-1:0]  cnt_b,
  input  logic [SHIFT_W-1:0]  cnt_shift,
  output logic                mac_begin,
  output logic                interrupt,
  output logic                restore,
  output logic                stalled,
  output logic [F_ADDR_W-1:0] ifmap_addr,
  output logic [W_ADDR_W-1:0] weight_addr,
  output logic [P_ADDR_W-1:0] psum_raddr,
  output logic [P_ADDR_W-1:0] psum_waddr,
  output logic                psum_we
);

  // Widths large enough that the address maths never overflows before the
  // final truncation to the pad address width.
  localparam int WM_W = CNT_A_W + CNT_B_W + 1;
  localparam int PM_W = SHIFT_W + CNT_B_W + 1;
  localparam int IF_W = ((F_ADDR_W > CNT_A_W) ? F_ADDR_W : CNT_A_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
`ifdef PAD_SYNC_HOLDOFF_EN
    ,
    S_HOLD = 2'd3
`endif
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_all_ready;
  logic w_any_full;
  logic r_all_ready_d;
  logic r_any_full_d;
  logic r_load_start_d;

  logic w_mac_begin;
  logic w_interrupt;
  logic w_restore;
  logic w_halted;

`ifdef PAD_SYNC_HOLDOFF_EN
  // The first full-clear cycle (spent in HALT) already counts as holdoff
  // cycle one, so HOLD only has to burn RESTORE_HOLD-2 further cycles before
  // restore may fire on the cycle the counter reads zero.
  localparam int HOLD_W      = (RESTORE_HOLD > 2) ? $clog2(RESTORE_HOLD) : 1;
  localparam int HOLD_LOAD_I = (RESTORE_HOLD > 1) ? RESTORE_HOLD - 2 : 0;

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_next;
`endif

  assign w_all_ready = &pad_ready;
  assign w_any_full  = |pad_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_all_ready_d  <= 1'b0;
      r_any_full_d   <= 1'b0;
      r_load_start_d <= 1'b0;
    end else begin
      r_all_ready_d  <= w_all_ready;
      r_any_full_d   <= w_any_full;
      r_load_start_d <= load_start;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
`ifdef PAD_SYNC_HOLDOFF_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
`ifdef PAD_SYNC_HOLDOFF_EN
      r_hold_cnt <= w_hold_cnt_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mac_begin     = 1'b0;
    w_interrupt     = 1'b0;
    w_restore       = 1'b0;
`ifdef PAD_SYNC_HOLDOFF_EN
    w_hold_cnt_next = r_hold_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if ((w_all_ready & ~r_all_ready_d) | (r_load_start_d & w_all_ready)) begin
          w_mac_begin  = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // mac_finish wins over a simultaneous full edge: no interrupt then.
        if (mac_finish) begin
          w_state_next = S_IDLE;
        end else if (w_any_full & ~r_any_full_d & w_all_ready) begin
          w_interrupt  = 1'b1;
          w_state_next = S_HALT;
        end
      end
      S_HALT: begin
`ifdef PAD_SYNC_HOLDOFF_EN
        if (~w_any_full) begin
          if ((RESTORE_HOLD <= 1) && w_all_ready) begin
            w_restore    = 1'b1;
            w_state_next = S_RUN;
          end else begin
            w_state_next    = S_HOLD;
            w_hold_cnt_next = HOLD_W'(HOLD_LOAD_I);
          end
        end
`else
        if (~w_any_full & w_all_ready) begin
          w_restore    = 1'b1;
          w_state_next = S_RUN;
        end
`endif
      end
`ifdef PAD_SYNC_HOLDOFF_EN
      S_HOLD: begin
        if (w_any_full) begin
          w_state_next = S_HALT;
        end else if (r_hold_cnt != '0) begin
          w_hold_cnt_next = r_hold_cnt - 1'b1;
        end else if (w_all_ready) begin
          w_restore    = 1'b1;
          w_state_next = S_RUN;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

`ifdef PAD_SYNC_HOLDOFF_EN
  assign w_halted = (r_state == S_HALT) || (r_state == S_HOLD);
`else
  assign w_halted = (r_state == S_HALT);
`endif

  // Nothing is announced in a reset cycle, even if the FSM was mid-flight.
  assign mac_begin = w_mac_begin & ~rst;
  assign interrupt = w_interrupt & ~rst;
  assign restore   = w_restore   & ~rst;
  assign stalled   = w_halted    & ~rst;

  // ---------------------------------------------------------------------------
  // Weight and ifmap read addresses
  // ---------------------------------------------------------------------------
  logic [WM_W-1:0]     w_weight_full;
  logic [IF_W-1:0]     w_cnt_a_x;
  logic [IF_W-1:0]     w_pnum_x;
  logic [IF_W-1:0]     w_ppt_x;
  logic [IF_W-1:0]     w_span;
  logic [IF_W-1:0]     w_ifmap_full;
  logic [F_ADDR_W-1:0] r_ifmap_addr;
  logic [W_ADDR_W-1:0] r_weight_addr;

  assign w_weight_full = WM_W'(cnt_a) + WM_W'(cnt_b) * WM_W'(conv_len);

  assign w_cnt_a_x = IF_W'(cnt_a);
  assign w_pnum_x  = IF_W'(pixel_num);
  assign w_ppt_x   = IF_W'(pixel_point);
  // Slots left before the ring end; once cnt_a passes them the read wraps.
  assign w_span    = w_pnum_x - w_ppt_x;

  always_comb begin
    w_ifmap_full = '0;
    if (pixel_num != '0) begin
      if (w_cnt_a_x >= w_span) begin
        w_ifmap_full = w_cnt_a_x + w_ppt_x - w_pnum_x;
      end else begin
        w_ifmap_full = w_ppt_x + w_cnt_a_x;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifmap_addr  <= '0;
      r_weight_addr <= '0;
    end else if (mul_enable & ~w_halted) begin
      r_ifmap_addr  <= F_ADDR_W'(w_ifmap_full);
      r_weight_addr <= W_ADDR_W'(w_weight_full);
    end
  end

  assign ifmap_addr  = r_ifmap_addr;
  assign weight_addr = r_weight_addr;

  // ---------------------------------------------------------------------------
  // Psum addresses
  // ---------------------------------------------------------------------------
  logic [PM_W-1:0]     w_psum_clip;
  logic [P_ADDR_W-1:0] r_psum_raddr;
  logic [P_ADDR_W-1:0] r_psum_lag;

  assign w_psum_clip = PM_W'(cnt_b) + PM_W'(cnt_shift) * PM_W'(filter_num);

  // r_psum_lag always trails the read address by a cycle; mode 0 writes
  // back through it, mode 1 writes in place at the read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psum_raddr <= '0;
      r_psum_lag   <= '0;
    end else begin
      r_psum_raddr <= mode ? P_ADDR_W'(w_psum_clip) : P_ADDR_W'(cnt_b);
      r_psum_lag   <= r_psum_raddr;
    end
  end

  assign psum_raddr = r_psum_raddr;
  assign psum_waddr = mode ? r_psum_raddr : r_psum_lag;
  assign psum_we    = ~rst & (psum_store | (mode & mac_finish));

endmodule

// File: tb/tb_pad_sync_addr_gen.sv
// tb/tb_pad_sync_addr_gen.sv - directed plus randomized check of pad_sync_addr_gen

module tb_pad_sync_addr_gen;

`ifdef PAD_SYNC_HOLDOFF_EN
  localparam int HOLD_EFF = 3;
  localparam bit HOLDOFF  = 1'b1;
`else
  localparam int HOLD_EFF = 1;
  localparam bit HOLDOFF  = 1'b0;
`endif
  localparam int NCYC = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pad_ready, pad_full;
  logic       load_start, mode;
  logic [3:0] conv_len, filter_num;
  logic [4:0] pixel_num, pixel_point;
  logic       mul_enable, psum_store, mac_finish;
  logic [3:0] cnt_a, cnt_b, cnt_shift;
  logic       mac_begin, interrupt, restore, stalled;
  logic [4:0] ifmap_addr;
  logic [7:0] weight_addr;
  logic [5:0] psum_raddr, psum_waddr;
  logic       psum_we;

  always #5 clk = ~clk;

  pad_sync_addr_gen #(.RESTORE_HOLD(3)) dut (
    .clk(clk), .rst(rst), .pad_ready(pad_ready), .pad_full(pad_full),
    .load_start(load_start), .mode(mode), .conv_len(conv_len),
    .filter_num(filter_num), .pixel_num(pixel_num), .pixel_point(pixel_point),
    .mul_enable(mul_enable), .psum_store(psum_store), .mac_finish(mac_finish),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_shift(cnt_shift),
    .mac_begin(mac_begin), .interrupt(interrupt), .restore(restore),
    .stalled(stalled), .ifmap_addr(ifmap_addr), .weight_addr(weight_addr),
    .psum_raddr(psum_raddr), .psum_waddr(psum_waddr), .psum_we(psum_we)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Reference model: busy/halted flags and a count of consecutive
  // full-clear cycles since the stall began; restore is due once that run
  // reaches the holdoff length and all pads are ready.
  bit m_busy, m_halted, m_ar_d, m_af_d, m_ls_d;
  int m_low, m_ifmap, m_weight, m_praddr, m_plag;

  int first_begin = -1, first_int = -1, first_restore = -1;
  int n_begin_early = 0, n_restore_win = 0, last_restore_win = -1;
  int exp_if[5] = '{9, 10, 11, 0, 1};

  task automatic set_inputs(input int cyc);
    if (cyc < 70) begin
      rst         = (cyc < 3);
      pad_ready   = (cyc < 10) ? 2'b01 : 2'b11;
      pad_full    = {((cyc >= 20 && cyc <= 24) || cyc == 29 || (cyc >= 31 && cyc <= 39)), 1'b0};
      load_start  = 1'b0;
      mul_enable  = (cyc >= 50 && cyc <= 54);
      pixel_num   = 5'd12;
      pixel_point = 5'd9;
      conv_len    = 4'd12;
      cnt_a       = (cyc >= 50 && cyc <= 54) ? 4'(cyc - 50) : 4'd0;
      cnt_b       = 4'd2;
      cnt_shift   = 4'd0;
      filter_num  = 4'd0;
      mode        = 1'b0;
      psum_store  = 1'b0;
      mac_finish  = 1'b0;
      if (cyc >= 60 && cyc <= 63) begin
        cnt_b      = (cyc - 60 > 2) ? 4'd2 : 4'(cyc - 60);
        psum_store = (cyc <= 62);
      end
      if (cyc == 65 || cyc == 66) begin
        mode       = 1'b1;
        cnt_b      = 4'd1;
        cnt_shift  = 4'd2;
        filter_num = 4'd3;
        mac_finish = (cyc == 66);
      end
    end else begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) pad_ready = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 4) == 0) pad_ready = 2'b11;
      if ($urandom_range(0, 11) == 0) pad_full = 2'($urandom_range(0, 3));
      load_start = ($urandom_range(0, 9) == 0);
      mac_finish = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      mul_enable = 1'($urandom);
      psum_store = 1'($urandom);
      cnt_a      = 4'($urandom);
      cnt_b      = 4'($urandom);
      cnt_shift  = 4'($urandom);
      conv_len   = 4'($urandom);
      filter_num = 4'($urandom);
      pixel_num  = 5'($urandom_range(0, 31));
      pixel_point = (pixel_num == 0) ? 5'($urandom) : 5'($urandom_range(0, int'(pixel_num) - 1));
    end
  endtask

  initial begin
    bit ar, af, e_begin, e_int, e_restore, e_stall, e_we;
    int e_waddr, span;
    rst = 1'b1; pad_ready = 0; pad_full = 0; load_start = 0; mode = 0;
    conv_len = 0; filter_num = 0; pixel_num = 0; pixel_point = 0;
    mul_enable = 0; psum_store = 0; mac_finish = 0; cnt_a = 0; cnt_b = 0; cnt_shift = 0;
    m_busy = 0; m_halted = 0; m_ar_d = 0; m_af_d = 0; m_ls_d = 0;
    m_low = 0; m_ifmap = 0; m_weight = 0; m_praddr = 0; m_plag = 0;
    #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      set_inputs(cyc);
      @(negedge clk);
      ar = &pad_ready;
      af = |pad_full;
      e_begin   = !rst && !m_busy && ((ar && !m_ar_d) || (m_ls_d && ar));
      e_int     = !rst && m_busy && !m_halted && !mac_finish && af && !m_af_d && ar;
      e_restore = !rst && m_halted && !af && ar && (m_low + 1 >= HOLD_EFF);
      e_stall   = !rst && m_halted;
      e_we      = !rst && (psum_store || (mode && mac_finish));
      e_waddr   = mode ? m_praddr : m_plag;
      if (cyc > 0) begin
        check("mac_begin",   32'(mac_begin),   32'(e_begin));
        check("interrupt",   32'(interrupt),   32'(e_int));
        check("restore",     32'(restore),     32'(e_restore));
        check("stalled",     32'(stalled),     32'(e_stall));
        check("ifmap_addr",  32'(ifmap_addr),  32'(m_ifmap));
        check("weight_addr", 32'(weight_addr), 32'(m_weight));
        check("psum_raddr",  32'(psum_raddr),  32'(m_praddr));
        check("psum_waddr",  32'(psum_waddr),  32'(e_waddr));
        check("psum_we",     32'(psum_we),     32'(e_we));
      end
      if (cyc == 1) begin
        check("rst_outputs", 32'({mac_begin, interrupt, restore, stalled, psum_we}), 32'(0));
        check("rst_addrs", 32'({ifmap_addr, weight_addr, psum_raddr, psum_waddr}), 32'(0));
      end
      if (cyc < 70) begin
        if (mac_begin && first_begin < 0) first_begin = cyc;
        if (mac_begin && cyc < 20) n_begin_early++;
        if (interrupt && first_int < 0) first_int = cyc;
        if (restore && first_restore < 0) first_restore = cyc;
        if (restore && cyc >= 28 && cyc <= 45) begin
          n_restore_win++;
          last_restore_win = cyc;
        end
        if (cyc == 21) check("stalled_c21", 32'(stalled), 32'(1));
        if (cyc == (HOLDOFF ? 28 : 26)) check("stalled_released", 32'(stalled), 32'(0));
        if (cyc >= 51 && cyc <= 55) check("ifmap_wrap", 32'(ifmap_addr), 32'(exp_if[cyc-51]));
        if (cyc == 55) check("weight_28", 32'(weight_addr), 32'(28));
        if (cyc == 62) check("psum_m0_lag", 32'({psum_raddr, psum_waddr}), 32'({6'd1, 6'd0}));
        if (cyc == 63) check("psum_m0_lag2", 32'({psum_raddr, psum_waddr}), 32'({6'd2, 6'd1}));
        if (cyc == 66) check("psum_m1_raddr", 32'(psum_raddr), 32'(7));
        if (cyc == 65 || cyc == 66) check("psum_m1_we", 32'(psum_we), 32'(mac_finish));
      end
      // advance the model across the rising edge
      if (rst) begin
        m_busy = 0; m_halted = 0; m_ar_d = 0; m_af_d = 0; m_ls_d = 0;
        m_low = 0; m_ifmap = 0; m_weight = 0; m_praddr = 0; m_plag = 0;
      end else begin
        if (mul_enable && !m_halted) begin
          m_weight = (int'(cnt_a) + int'(cnt_b) * int'(conv_len)) % 256;
          span = int'(pixel_num) - int'(pixel_point);
          if (pixel_num == 0) m_ifmap = 0;
          else if (int'(cnt_a) >= span) m_ifmap = (int'(cnt_a) - span) % 32;
          else m_ifmap = (int'(pixel_point) + int'(cnt_a)) % 32;
        end
        m_plag   = m_praddr;
        m_praddr = mode ? (int'(cnt_b) + int'(cnt_shift) * int'(filter_num)) % 64 : int'(cnt_b);
        if (e_begin) begin
          m_busy = 1;
        end else if (m_busy && !m_halted) begin
          if (mac_finish) m_busy = 0;
          else if (e_int) begin
            m_halted = 1;
            m_low    = 0;
          end
        end else if (m_halted) begin
          if (e_restore) m_halted = 0;
          else m_low = af ? 0 : ((m_low < 1000) ? m_low + 1 : m_low);
        end
        m_ar_d = ar;
        m_af_d = af;
        m_ls_d = load_start;
      end
      @(posedge clk);
      #1;
    end
    check("first_begin", 32'(first_begin), 32'(10));
    check("begin_once", 32'(n_begin_early), 32'(1));
    check("first_interrupt", 32'(first_int), 32'(20));
    check("first_restore", 32'(first_restore), 32'(HOLDOFF ? 27 : 25));
    check("restore_count_win", 32'(n_restore_win), 32'(HOLDOFF ? 1 : 2));
    check("restore_last_win", 32'(last_restore_win), 32'(HOLDOFF ? 42 : 40));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
